// File: rtl/call_int_sequencer_if.sv
// Handshake bundle between the main controller, interrupt register and the call/interrupt sequencer.
// master = sequencer side, slave = controller/datapath side.
interface call_int_sequencer_if #(
  parameter int NUM_IRQ = 4
);
  logic               call_req;
  logic               boundary;
  logic [NUM_IRQ-1:0] irq_pend;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               int_en;
  logic               dataReady;
  logic               busy;
  logic               done;
  logic [1:0]         SPctrl;
  logic               MARld;
  logic [2:0]         writeSrc;
  logic               DRAMwriteEnable;
  logic [1:0]         PCctrl;
  logic [7:0]         vec_addr;
  logic               intDisable;
  logic [NUM_IRQ-1:0] clrPend;
  logic               fault;

  modport master (
    input  call_req, boundary, irq_pend, irq_mask, int_en, dataReady,
    output busy, done, SPctrl, MARld, writeSrc, DRAMwriteEnable, PCctrl,
           vec_addr, intDisable, clrPend, fault
  );

  modport slave (
    output call_req, boundary, irq_pend, irq_mask, int_en, dataReady,
    input  busy, done, SPctrl, MARld, writeSrc, DRAMwriteEnable, PCctrl,
           vec_addr, intDisable, clrPend, fault
  );
endinterface

// File: rtl/call_int_sequencer.sv
// Call/interrupt entry sequencer: pushes PUSH_WORDS context words, then vectors to the highest-priority
// unmasked interrupt; call latency 4+2*PUSH_WORDS-2 cycles to done, +1 for VEC; each write waits on dataReady.
module call_int_sequencer #(
  parameter int         NUM_IRQ    = 4,
  parameter int         PUSH_WORDS = 2,
  parameter logic [7:0] VEC_BASE   = 8'hF0,
  parameter int         WAIT_MAX   = 15
) (
  input logic               clk,
  input logic               rst,
  call_int_sequencer_if.master bus
);
  localparam int SELW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int WCW  = $clog2(WAIT_MAX + 1);
  localparam logic [1:0]     LAST_WORD = 2'(PUSH_WORDS - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

  typedef enum logic [2:0] {S_IDLE, S_DEC, S_WR, S_CHK, S_VEC, S_FIN, S_FAULT} state_e;
  typedef enum logic {M_CALL, M_INT} mode_e;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [1:0]        word_q, word_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic [SELW-1:0]   sel_q, sel_d;

  logic [NUM_IRQ-1:0] eligible;
  logic               any_elig;
  logic [SELW-1:0]    sel_c;

  assign eligible = bus.irq_pend & ~bus.irq_mask & {NUM_IRQ{bus.int_en}};
  assign any_elig = |eligible;

  // Scan downwards so the lowest set index (highest priority) is the last write.
  always_comb begin
    sel_c = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_c = SELW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_CALL;
      word_q  <= '0;
      wait_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      word_q  <= word_d;
      wait_q  <= wait_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    mode_d              = mode_q;
    word_d              = word_q;
    wait_d              = wait_q;
    sel_d               = sel_q;
    bus.busy            = 1'b0;
    bus.done            = 1'b0;
    bus.SPctrl          = 2'b00;
    bus.MARld           = 1'b0;
    bus.writeSrc        = 3'd0;
    bus.DRAMwriteEnable = 1'b0;
    bus.PCctrl          = 2'b00;
    bus.vec_addr        = 8'h00;
    bus.intDisable      = 1'b0;
    bus.clrPend         = '0;
    bus.fault           = 1'b0;

    case (state_q)
      S_IDLE: begin
        word_d = '0;
        wait_d = '0;
        if (bus.call_req) begin
          mode_d  = M_CALL;
          state_d = S_DEC;
        end else if (bus.boundary && any_elig) begin
          mode_d  = M_INT;
          state_d = S_DEC;
        end
      end
      S_DEC: begin
        bus.busy     = 1'b1;
        bus.SPctrl   = 2'b01;
        bus.MARld    = 1'b1;
        bus.writeSrc = {1'b0, word_q};
        state_d      = S_WR;
      end
      S_WR: begin
        bus.busy            = 1'b1;
        bus.DRAMwriteEnable = 1'b1;
        bus.writeSrc        = {1'b0, word_q};
        // A completing write in the last allowed cycle still counts as success.
        if (bus.dataReady) begin
          wait_d = '0;
          if (word_q == LAST_WORD) begin
            state_d = S_CHK;
          end else begin
            word_d  = word_q + 2'd1;
            state_d = S_DEC;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_CHK: begin
        bus.busy = 1'b1;
        if (mode_q == M_CALL) begin
          bus.PCctrl = 2'b01;
          if (any_elig) begin
            sel_d   = sel_c;
            mode_d  = M_INT;
            word_d  = '0;
            state_d = S_DEC;
          end else begin
            state_d = S_FIN;
          end
        end else if (any_elig) begin
          sel_d   = sel_c;
          state_d = S_VEC;
        end else begin
          state_d = S_FIN;
        end
      end
      S_VEC: begin
        bus.busy       = 1'b1;
        bus.PCctrl     = 2'b10;
        bus.vec_addr   = VEC_BASE + {{(8-SELW){1'b0}}, sel_q};
        bus.intDisable = 1'b1;
        bus.clrPend    = NUM_IRQ'(1) << sel_q;
        state_d        = S_FIN;
      end
      S_FIN: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        word_d   = '0;
        state_d  = S_IDLE;
      end
      S_FAULT: begin
        bus.fault = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_call_int_sequencer.sv
// Directed bench for call_int_sequencer: call, interrupt, masking, nested entry, slow RAM and timeout.
module tb_call_int_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  call_int_sequencer_if #(.NUM_IRQ(4)) bus ();

  call_int_sequencer #(
    .NUM_IRQ(4), .PUSH_WORDS(2), .VEC_BASE(8'hF0), .WAIT_MAX(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  // per-run statistics
  int done_at, fault_at, n_dec, n_we, n_pc1, n_pc2, n_intdis, n_done, n_together;
  logic [31:0] ws_seq;
  logic [7:0]  vec_seen;
  logic [3:0]  clr_seen;
  int          delay_left;
  bit          irq_on_wr2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] out_vec();
    return {16'h0, bus.busy, bus.done, bus.SPctrl, bus.MARld, bus.writeSrc,
            bus.DRAMwriteEnable, bus.PCctrl, bus.intDisable, bus.fault, 3'b0};
  endfunction

  // Caller has already raised call_req or boundary; this clocks and gathers what the DUT did.
  task automatic run_seq(input int maxc);
    done_at = 0; fault_at = 0; n_dec = 0; n_we = 0; n_pc1 = 0; n_pc2 = 0;
    n_intdis = 0; n_done = 0; n_together = 0; ws_seq = 0; vec_seen = 0; clr_seen = 0;
    for (int c = 1; c <= maxc; c++) begin
      tick();
      bus.call_req = 1'b0;
      bus.boundary = 1'b0;
      if (bus.SPctrl == 2'b01) begin
        n_dec++;
        ws_seq = (ws_seq << 4) | 32'(bus.writeSrc);
      end
      if (bus.DRAMwriteEnable) begin
        n_we++;
        if (delay_left > 0) begin
          bus.dataReady = 1'b0;
          delay_left--;
        end else begin
          bus.dataReady = 1'b1;
        end
        if (irq_on_wr2 && n_we == 2) bus.irq_pend = 4'b0100;
      end else begin
        bus.dataReady = 1'b1;
      end
      if (bus.PCctrl == 2'b01) n_pc1++;
      if (bus.PCctrl == 2'b10) begin
        n_pc2++;
        vec_seen = bus.vec_addr;
      end
      if (bus.intDisable) n_intdis++;
      if (bus.intDisable && bus.clrPend != 0) n_together++;
      clr_seen = clr_seen | bus.clrPend;
      if (bus.fault) begin
        fault_at = c;
        break;
      end
      if (bus.done) begin
        n_done++;
        done_at = c;
        break;
      end
    end
    // one more cycle to confirm the sequencer released the datapath with a single done
    if (fault_at == 0) begin
      tick();
      if (bus.done) n_done++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.call_req = 0; bus.boundary = 0; bus.irq_pend = 0; bus.irq_mask = 0;
    bus.int_en = 1; bus.dataReady = 1;
    delay_left = 0; irq_on_wr2 = 0;
    tick(); tick();
    check("reset_outputs", out_vec(), 32'h0);
    check("reset_vec_clr", {bus.vec_addr, 4'h0, bus.clrPend}, 32'h0);
    rst = 1'b0;
    tick();
    check("idle_after_reset", out_vec(), 32'h0);

    // plain call
    bus.call_req = 1;
    run_seq(20);
    check("call_done_at", done_at, 6);
    check("call_dec_pulses", n_dec, 2);
    check("call_writesrc_seq", ws_seq, 32'h01);
    check("call_we_cycles", n_we, 2);
    check("call_pc01", n_pc1, 1);
    check("call_no_vec", n_pc2, 0);
    check("call_no_intdis", {n_intdis[15:0], 12'h0, clr_seen}, 32'h0);
    check("call_single_done", n_done, 1);
    check("call_idle_after", bus.busy, 0);

    // interrupt at boundary, channel 1 wins over 3
    bus.irq_pend = 4'b1010; bus.irq_mask = 0; bus.int_en = 1;
    bus.boundary = 1;
    run_seq(20);
    check("int_done_at", done_at, 7);
    check("int_vec_addr", vec_seen, 8'hF1);
    check("int_clrpend", clr_seen, 4'b0010);
    check("int_intdis_with_clr", n_together, 1);
    check("int_no_pc01", n_pc1, 0);
    check("int_dec_pulses", n_dec, 2);
    bus.irq_pend = 0;

    // masked channel
    bus.irq_pend = 4'b0001; bus.irq_mask = 4'b0001; bus.int_en = 1;
    bus.boundary = 1;
    tick(); bus.boundary = 0; tick();
    check("masked_stays_idle", out_vec(), 32'h0);
    // globally disabled
    bus.irq_mask = 0; bus.int_en = 0;
    bus.boundary = 1;
    tick(); bus.boundary = 0; tick();
    check("disabled_stays_idle", out_vec(), 32'h0);
    bus.irq_pend = 0; bus.int_en = 1;

    // call with irq 2 arriving during the second write: nested entry
    irq_on_wr2 = 1;
    bus.call_req = 1;
    run_seq(30);
    irq_on_wr2 = 0;
    check("nest_dec_pulses", n_dec, 4);
    check("nest_writesrc_seq", ws_seq, 32'h0101);
    check("nest_pc01", n_pc1, 1);
    check("nest_pc10", n_pc2, 1);
    check("nest_vec_addr", vec_seen, 8'hF2);
    check("nest_clrpend", clr_seen, 4'b0100);
    check("nest_done_at", done_at, 12);
    check("nest_single_done", n_done, 1);
    bus.irq_pend = 0;

    // first write slow by 3 cycles
    delay_left = 3;
    bus.call_req = 1;
    run_seq(30);
    check("slow_done_at", done_at, 9);
    check("slow_we_cycles", n_we, 5);

    // RAM never answers: timeout fault
    delay_left = 1000;
    bus.call_req = 1;
    run_seq(40);
    check("fault_at", fault_at, 17);
    check("fault_wr_cycles", n_we, 15);
    check("fault_busy", bus.busy, 0);
    bus.call_req = 1;
    tick(); bus.call_req = 0; tick();
    check("fault_ignores_call", out_vec(), 32'h8);
    delay_left = 0; bus.dataReady = 1;
    rst = 1; tick(); rst = 0;
    check("reset_clears_fault", out_vec(), 32'h0);
    bus.call_req = 1;
    run_seq(20);
    check("call_after_reset", done_at, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/call_int_sequencer.md
Name: call_int_sequencer

Overview:
- Parametrised multi-cycle sequencer for subroutine-call and interrupt entry in the accumulator processor. Replaces the fixed push chain in the main controller.
- Pushes a configurable number of context words onto the data-RAM stack, waiting on `dataReady` for each write. Then chains into a prioritised, maskable, multi-channel interrupt entry before returning control.
- Sits beside the main controller. The controller hands off on CALL decode or at an instruction boundary, and resumes when `done` pulses.

Parameters:
- `NUM_IRQ`, 4, number of interrupt request channels (1..8); channel 0 has highest priority.
- `PUSH_WORDS`, 2, context words pushed per entry (1..4); word 0 = PC, word 1 = CC, others = ACC/user.
- `VEC_BASE`, 8'hF0, base of interrupt vector table; vector for channel k = `VEC_BASE` + k.
- `WAIT_MAX`, 15, maximum cycles to wait for `dataReady` per write before fault.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `call_req` in 1: one-cycle pulse from controller; start a subroutine call.
- `boundary` in 1: controller at instruction boundary; may start an interrupt entry.
- `irq_pend` in `NUM_IRQ`: pending flags from the interrupt register.
- `irq_mask` in `NUM_IRQ`: 1 = channel masked.
- `int_en` in 1: global interrupt enable.
- `dataReady` in 1: data RAM write complete.
- `busy` out 1: sequencer owns the datapath.
- `done` out 1: one-cycle pulse; controller resumes at fetch.
- `SPctrl` out 2: 00 hold, 01 decrement, 10 increment, 11 reserved.
- `MARld` out 1: load MAR from SP.
- `writeSrc` out 3: push-word select (= word index).
- `DRAMwriteEnable` out 1: data-RAM write strobe, held until `dataReady`.
- `PCctrl` out 2: 00 hold, 01 load call target (IR operand), 10 load vector.
- `vec_addr` out 8: vector address, valid while `PCctrl`=10.
- `intDisable` out 1: pulse, clears the global enable.
- `clrPend` out `NUM_IRQ`: one-hot pulse, clears the serviced pending bit.
- `fault` out 1: sticky; set on write timeout.

Behaviour:
- Reset: state IDLE.
  - All outputs 0 / 00, including `fault`.
  - Word counter 0, wait counter 0.
- Interrupt eligibility: `eligible` = `irq_pend` & ~`irq_mask` & {`int_en`}. `sel` = lowest set index of `eligible`.
- State IDLE:
  - `call_req` → DEC with `mode`=CALL.
  - Else `boundary` & |`eligible` → DEC with `mode`=INT.
  - `call_req` wins when both are asserted.
  - `busy` = 0 only in IDLE and FAULT.
- State DEC (1 cycle): `SPctrl`=01, `MARld`=1, `writeSrc`=word index → WR.
- State WR:
  - `DRAMwriteEnable`=1, `writeSrc` held.
  - Stay while `dataReady`=0; the wait counter increments each cycle.
  - If `dataReady`=1: clear the wait counter. If word index = `PUSH_WORDS`-1 → CHK; else increment word index → DEC.
  - If the wait counter reaches `WAIT_MAX` with `dataReady`=0 → FAULT. `dataReady` in the same cycle takes precedence.
- State CHK (1 cycle):
  - `mode`=CALL: `PCctrl`=01.
    - If |`eligible` this cycle: latch `sel`, set `mode`=INT, reset word index → DEC. This nests an interrupt push on top of the call frame.
    - Else → FIN.
  - `mode`=INT: latch `sel` (re-evaluated here; a higher-priority arrival preempts) → VEC.
  - If `eligible` is 0 in INT mode (pending withdrawn): → FIN with no vector load.
- State VEC (1 cycle):
  - `PCctrl`=10, `vec_addr`=`VEC_BASE`+`sel` (8-bit wrap).
  - `intDisable`=1, `clrPend`[`sel`]=1 → FIN.
- State FIN (1 cycle): `done`=1, word index 0 → IDLE.
- State FAULT:
  - `fault`=1; all strobes 0; `busy`=0.
  - Exit only via `rst`.
  - `call_req` and `boundary` are ignored.
- Latency, call with `PUSH_WORDS`=2, `dataReady` immediate: DEC, WR, DEC, WR, CHK, FIN = `done` 6 cycles after `call_req`.
- Latency, interrupt: adds VEC, so 7 cycles.
- Each extra wait cycle in WR adds 1.
- `rst` mid-sequence returns to IDLE next edge. Partially adjusted SP is not restored; SP is owned by its register.
- `call_req` / `boundary` while busy: ignored (not queued).

Test Plan:
- Plain call, `PUSH_WORDS`=2, `dataReady` tied 1, no irq:
  - → `SPctrl`=01 for exactly 2 cycles, `DRAMwriteEnable` with `writeSrc` 0 then 1.
  - → `PCctrl`=01 in CHK; `done` at cycle 6; `intDisable`/`clrPend` never asserted.
- Interrupt at boundary, `irq_pend`=4'b1010, mask 0, `int_en`=1:
  - → channel 1 serviced, `vec_addr`=8'hF1.
  - → `clrPend`=4'b0010 and `intDisable` pulse together; `done` at cycle 7.
- Masked and disabled interrupts:
  - `irq_pend`=4'b0001 with `irq_mask`=4'b0001 → `boundary` ignored, stays IDLE.
  - Repeat with `int_en`=0 → same.
- Call with `irq_pend`[2] rising during the second WR:
  - → after call pushes, 2 more pushes (4 total `SPctrl`=01 pulses).
  - → `PCctrl`=01 then later 10 with `vec_addr`=8'hF2; single `done`.
- `dataReady` delayed 3 cycles on the first write → `DRAMwriteEnable` held 4 cycles; `done` at cycle 9.
- `dataReady` held 0, `WAIT_MAX`=15:
  - → `fault`=1 after 15 WR cycles, `busy`=0.
  - → next `call_req` ignored; `rst` clears `fault` and returns to IDLE.
